// File: rtl/pc_redirect_ctrl_if.sv
// Execute-stage redirect requests and the PC-side control bus of pc_redirect_ctrl.
// master: execute stage / PC side; slave: the redirect controller.
interface pc_redirect_ctrl_if;
   logic        ihit;
   logic        ex_valid;
   logic        ex_branch;
   logic        ex_taken;
   logic        ex_jump;
   logic        ex_jr;
   logic [15:0] ex_br_imm;
   logic [25:0] ex_jmp_tgt;
   logic [31:0] ex_jr_tgt;
   logic [1:0]  PCSrc;
   logic [15:0] br_addr;
   logic [25:0] jmp_addr;
   logic [31:0] jr_addr;
   logic        flush;

   modport master (
      output ihit, ex_valid, ex_branch, ex_taken, ex_jump, ex_jr,
             ex_br_imm, ex_jmp_tgt, ex_jr_tgt,
      input  PCSrc, br_addr, jmp_addr, jr_addr, flush
   );

   modport slave (
      input  ihit, ex_valid, ex_branch, ex_taken, ex_jump, ex_jr,
             ex_br_imm, ex_jmp_tgt, ex_jr_tgt,
      output PCSrc, br_addr, jmp_addr, jr_addr, flush
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Latches the winning execute-stage redirect and holds it until the PC loads on ihit.
// Flushes IF/ID while pending; counts consumed redirects and flags overruns.
module pc_redirect_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   pc_redirect_ctrl_if.slave bus,
   output logic             redirect_pending,
   output logic             overrun,
   output logic [CNT_W-1:0] redirect_cnt
);

   typedef enum logic {IDLE, REDIRECT} state_t;

   state_t           state, next_state;
   logic [1:0]       sel_q, sel_d;
   logic [15:0]      br_q, br_d;
   logic [25:0]      jmp_q, jmp_d;
   logic [31:0]      jr_q, jr_d;
   logic             overrun_d;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state        <= IDLE;
         sel_q        <= '0;
         br_q         <= '0;
         jmp_q        <= '0;
         jr_q         <= '0;
         overrun      <= 1'b0;
         redirect_cnt <= '0;
      end else begin
         state        <= next_state;
         sel_q        <= sel_d;
         br_q         <= br_d;
         jmp_q        <= jmp_d;
         jr_q         <= jr_d;
         overrun      <= overrun_d;
         redirect_cnt <= cnt_d;
      end
   end

   always_comb begin
      next_state       = state;
      sel_d            = sel_q;
      br_d             = br_q;
      jmp_d            = jmp_q;
      jr_d             = jr_q;
      overrun_d        = overrun;
      cnt_d            = redirect_cnt;
      bus.PCSrc        = '0;
      bus.flush        = 1'b0;
      redirect_pending = 1'b0;
      case (state)
         IDLE: begin
            // Priority jr > jump > taken branch; only the winner's target loads.
            if (bus.ex_valid) begin
               if (bus.ex_jr) begin
                  sel_d      = 2'd3;
                  jr_d       = bus.ex_jr_tgt;
                  next_state = REDIRECT;
               end else if (bus.ex_jump) begin
                  sel_d      = 2'd2;
                  jmp_d      = bus.ex_jmp_tgt;
                  next_state = REDIRECT;
               end else if (bus.ex_branch && bus.ex_taken) begin
                  sel_d      = 2'd1;
                  br_d       = bus.ex_br_imm;
                  next_state = REDIRECT;
               end
            end
         end
         REDIRECT: begin
            bus.PCSrc        = sel_q;
            bus.flush        = 1'b1;
            redirect_pending = 1'b1;
            if (bus.ex_valid) overrun_d = 1'b1;
            if (bus.ihit) begin
               next_state = IDLE;
               if (redirect_cnt != '1) cnt_d = redirect_cnt + CNT_W'(1);
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign bus.br_addr  = br_q;
   assign bus.jmp_addr = jmp_q;
   assign bus.jr_addr  = jr_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; a second narrow-counter instance exercises saturation.
module tb_pc_redirect_ctrl;
   logic        CLK;
   logic        nRST;
   logic        redirect_pending, overrun;
   logic [15:0] redirect_cnt;
   logic        redirect_pending2, overrun2;
   logic [2:0]  redirect_cnt2;
   int          errors = 0;
   int          checks = 0;

   pc_redirect_ctrl_if bus ();
   pc_redirect_ctrl_if bus2 ();

   assign bus2.ihit       = bus.ihit;
   assign bus2.ex_valid   = bus.ex_valid;
   assign bus2.ex_branch  = bus.ex_branch;
   assign bus2.ex_taken   = bus.ex_taken;
   assign bus2.ex_jump    = bus.ex_jump;
   assign bus2.ex_jr      = bus.ex_jr;
   assign bus2.ex_br_imm  = bus.ex_br_imm;
   assign bus2.ex_jmp_tgt = bus.ex_jmp_tgt;
   assign bus2.ex_jr_tgt  = bus.ex_jr_tgt;

   pc_redirect_ctrl #(.CNT_W(16)) dut (
      .CLK              (CLK),
      .nRST             (nRST),
      .bus              (bus.slave),
      .redirect_pending (redirect_pending),
      .overrun          (overrun),
      .redirect_cnt     (redirect_cnt)
   );

   pc_redirect_ctrl #(.CNT_W(3)) dut_sat (
      .CLK              (CLK),
      .nRST             (nRST),
      .bus              (bus2.slave),
      .redirect_pending (redirect_pending2),
      .overrun          (overrun2),
      .redirect_cnt     (redirect_cnt2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_ex;
      bus.ex_valid   = 1'b0;
      bus.ex_branch  = 1'b0;
      bus.ex_taken   = 1'b0;
      bus.ex_jump    = 1'b0;
      bus.ex_jr      = 1'b0;
      bus.ex_br_imm  = '0;
      bus.ex_jmp_tgt = '0;
      bus.ex_jr_tgt  = '0;
   endtask

   task automatic test_reset;
      nRST = 1'b0;
      bus.ihit = 1'b0;
      clear_ex();
      bus.ex_valid = 1'b1;
      bus.ex_jump = 1'b1;
      bus.ex_jmp_tgt = 26'h0000123;
      tick();
      tick();
      checks++;
      if ({bus.PCSrc, bus.flush, redirect_pending, overrun} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: PCSrc=%0d flush=%b pend=%b ovr=%b, want all 0",
                  bus.PCSrc, bus.flush, redirect_pending, overrun);
      end
      checks++;
      if ({bus.br_addr, bus.jmp_addr, bus.jr_addr} !== 74'b0) begin
         errors++;
         $display("FAIL reset_tgt: br=%h jmp=%h jr=%h, want 0", bus.br_addr, bus.jmp_addr, bus.jr_addr);
      end
      checks++;
      if (redirect_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d want 0", redirect_cnt);
      end
      nRST = 1'b1;
      clear_ex();
   endtask

   task automatic test_jump;
      bus.ex_valid = 1'b1;
      bus.ex_jump = 1'b1;
      bus.ex_jmp_tgt = 26'h0000040;
      tick();
      clear_ex();
      checks++;
      if ({bus.PCSrc, bus.jmp_addr, bus.flush, redirect_pending} !== {2'd2, 26'h40, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL jump_issue: PCSrc=%0d jmp=%h flush=%b pend=%b, want 2 40 1 1",
                  bus.PCSrc, bus.jmp_addr, bus.flush, redirect_pending);
      end
      bus.ihit = 1'b1;
      tick();
      bus.ihit = 1'b0;
      checks++;
      if ({bus.PCSrc, bus.flush, redirect_pending, redirect_cnt} !== {2'd0, 1'b0, 1'b0, 16'd1}) begin
         errors++;
         $display("FAIL jump_done: PCSrc=%0d flush=%b pend=%b cnt=%0d, want 0 0 0 1",
                  bus.PCSrc, bus.flush, redirect_pending, redirect_cnt);
      end
   endtask

   task automatic test_branch_miss;
      bus.ex_valid = 1'b1;
      bus.ex_branch = 1'b1;
      bus.ex_taken = 1'b1;
      bus.ex_br_imm = 16'hFFFC;
      tick();
      clear_ex();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({bus.PCSrc, bus.br_addr, bus.flush} !== {2'd1, 16'hFFFC, 1'b1}) begin
            errors++;
            $display("FAIL branch_hold[%0d]: PCSrc=%0d br=%h flush=%b, want 1 fffc 1",
                     i, bus.PCSrc, bus.br_addr, bus.flush);
         end
         bus.ihit = (i == 3);
         tick();
      end
      bus.ihit = 1'b0;
      checks++;
      if ({bus.PCSrc, bus.flush, redirect_cnt} !== {2'd0, 1'b0, 16'd2}) begin
         errors++;
         $display("FAIL branch_done: PCSrc=%0d flush=%b cnt=%0d, want 0 0 2",
                  bus.PCSrc, bus.flush, redirect_cnt);
      end
   endtask

   task automatic test_no_redirect;
      bus.ex_valid = 1'b1;
      bus.ex_branch = 1'b1;
      bus.ex_br_imm = 16'h0111;
      tick();
      clear_ex();
      checks++;
      if ({bus.PCSrc, bus.flush, redirect_pending, redirect_cnt, bus.br_addr} !==
          {2'd0, 1'b0, 1'b0, 16'd2, 16'hFFFC}) begin
         errors++;
         $display("FAIL not_taken: PCSrc=%0d flush=%b pend=%b cnt=%0d br=%h, want 0 0 0 2 fffc",
                  bus.PCSrc, bus.flush, redirect_pending, redirect_cnt, bus.br_addr);
      end
      bus.ex_valid = 1'b1;
      bus.ex_taken = 1'b1;
      bus.ex_br_imm = 16'h0222;
      tick();
      clear_ex();
      checks++;
      if ({bus.PCSrc, redirect_pending, bus.br_addr} !== {2'd0, 1'b0, 16'hFFFC}) begin
         errors++;
         $display("FAIL taken_no_branch: PCSrc=%0d pend=%b br=%h, want 0 0 fffc",
                  bus.PCSrc, redirect_pending, bus.br_addr);
      end
   endtask

   task automatic test_priority;
      bus.ex_valid = 1'b1;
      bus.ex_jr = 1'b1;
      bus.ex_jump = 1'b1;
      bus.ex_branch = 1'b1;
      bus.ex_taken = 1'b1;
      bus.ex_jr_tgt = 32'h00001000;
      bus.ex_jmp_tgt = 26'h3FFFFFF;
      bus.ex_br_imm = 16'h1234;
      tick();
      clear_ex();
      checks++;
      if ({bus.PCSrc, bus.jr_addr, bus.jmp_addr, bus.br_addr} !==
          {2'd3, 32'h1000, 26'h40, 16'hFFFC}) begin
         errors++;
         $display("FAIL priority: PCSrc=%0d jr=%h jmp=%h br=%h, want 3 1000 40 fffc",
                  bus.PCSrc, bus.jr_addr, bus.jmp_addr, bus.br_addr);
      end
      bus.ihit = 1'b1;
      tick();
      bus.ihit = 1'b0;
      checks++;
      if ({bus.PCSrc, bus.jr_addr, redirect_cnt} !== {2'd0, 32'h1000, 16'd3}) begin
         errors++;
         $display("FAIL priority_done: PCSrc=%0d jr=%h cnt=%0d, want 0 1000 3",
                  bus.PCSrc, bus.jr_addr, redirect_cnt);
      end
   endtask

   task automatic test_overrun_reset;
      bus.ex_valid = 1'b1;
      bus.ex_jump = 1'b1;
      bus.ex_jmp_tgt = 26'h0ABCDEF;
      tick();
      clear_ex();
      checks++;
      if ({bus.PCSrc, overrun} !== {2'd2, 1'b0}) begin
         errors++;
         $display("FAIL ovr_pre: PCSrc=%0d ovr=%b, want 2 0", bus.PCSrc, overrun);
      end
      bus.ex_valid = 1'b1;
      bus.ex_jr = 1'b1;
      bus.ex_jr_tgt = 32'hDEAD0000;
      tick();
      clear_ex();
      checks++;
      if ({overrun, bus.PCSrc, bus.jr_addr, bus.jmp_addr, redirect_pending} !==
          {1'b1, 2'd2, 32'h1000, 26'h0ABCDEF, 1'b1}) begin
         errors++;
         $display("FAIL overrun: ovr=%b PCSrc=%0d jr=%h jmp=%h pend=%b, want 1 2 1000 abcdef 1",
                  overrun, bus.PCSrc, bus.jr_addr, bus.jmp_addr, redirect_pending);
      end
      tick();
      checks++;
      if ({overrun, bus.PCSrc} !== {1'b1, 2'd2}) begin
         errors++;
         $display("FAIL overrun_sticky: ovr=%b PCSrc=%0d, want 1 2", overrun, bus.PCSrc);
      end
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      checks++;
      if ({redirect_pending, overrun, bus.PCSrc, bus.flush, redirect_cnt, bus.jmp_addr} !==
          {1'b0, 1'b0, 2'd0, 1'b0, 16'd0, 26'd0}) begin
         errors++;
         $display("FAIL mid_reset: pend=%b ovr=%b PCSrc=%0d flush=%b cnt=%0d jmp=%h, want all 0",
                  redirect_pending, overrun, bus.PCSrc, bus.flush, redirect_cnt, bus.jmp_addr);
      end
   endtask

   task automatic test_same_edge;
      bus.ex_valid = 1'b1;
      bus.ex_jump = 1'b1;
      bus.ex_jmp_tgt = 26'h0000010;
      tick();
      clear_ex();
      bus.ex_valid = 1'b1;
      bus.ex_branch = 1'b1;
      bus.ex_taken = 1'b1;
      bus.ex_br_imm = 16'h0008;
      bus.ihit = 1'b1;
      tick();
      clear_ex();
      bus.ihit = 1'b0;
      checks++;
      if ({redirect_pending, overrun, bus.PCSrc, bus.br_addr, redirect_cnt} !==
          {1'b0, 1'b1, 2'd0, 16'h0, 16'd1}) begin
         errors++;
         $display("FAIL same_edge: pend=%b ovr=%b PCSrc=%0d br=%h cnt=%0d, want 0 1 0 0000 1",
                  redirect_pending, overrun, bus.PCSrc, bus.br_addr, redirect_cnt);
      end
      tick();
      checks++;
      if ({redirect_pending, bus.flush} !== 2'b00) begin
         errors++;
         $display("FAIL same_edge_drop: pend=%b flush=%b, want 0 0", redirect_pending, bus.flush);
      end
   endtask

   task automatic test_saturation;
      int unsigned exp2;
      for (int i = 0; i < 8; i++) begin
         bus.ex_valid = 1'b1;
         bus.ex_jump = 1'b1;
         bus.ex_jmp_tgt = 26'(i + 1);
         tick();
         clear_ex();
         bus.ihit = 1'b1;
         tick();
         bus.ihit = 1'b0;
         exp2 = (i + 2 > 7) ? 7 : i + 2;
         checks++;
         if (redirect_cnt2 !== 3'(exp2)) begin
            errors++;
            $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, redirect_cnt2, exp2);
         end
      end
      checks++;
      if (redirect_cnt !== 16'd9) begin
         errors++;
         $display("FAIL wide_cnt: got %0d want 9", redirect_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_jump();
      test_branch_miss();
      test_no_redirect();
      test_priority();
      test_overrun_reset();
      test_same_edge();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
